// File: rtl/i2c_pkg.sv
// Shared I2C definitions: state list, ACK/NACK bus levels, default sizing.
// Used by the receptor and kept in step with the transaction generator.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_WR_BYTE   = 3'd3,
        ST_WR_ACK    = 3'd4,
        ST_RD_BYTE   = 3'd5,
        ST_RD_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } i2c_state_t;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam int DEFAULT_ADDR_WIDTH = 7;
    localparam int DEFAULT_DATA_BYTES = 2;

endpackage

// File: rtl/i2c_bus_edges.sv
// Registers scl/sda once per clk and flags SCL edges and the SDA-rise-while-SCL-high
// bus condition. scl and sda are already in the clk domain, so no synchronizers.
module i2c_bus_edges
    import i2c_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic bus_cond
);

    logic scl_q;
    logic sda_q;

    // scl_q resets high so an idle-high SCL does not look like a rising edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_q <= 1'b1;
            sda_q <= 1'b0;
        end else begin
            scl_q <= scl;
            sda_q <= sda;
        end
    end

    assign scl_rise = scl & ~scl_q;
    assign scl_fall = ~scl & scl_q;
    assign bus_cond = scl & scl_q & sda & ~sda_q;

endmodule

// File: rtl/i2c_receptor.sv
// I2C target stage: decodes address + R/W, ACKs a match, then captures a write word
// or serves a read word. Bus outputs only change on the clk after an SCL fall.
module i2c_receptor
    import i2c_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_BYTES = DEFAULT_DATA_BYTES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    scl,
    input  logic                    sda_in,
    input  logic [ADDR_WIDTH-1:0]   own_addr,
    input  logic [8*DATA_BYTES-1:0] rd_data,
    output logic                    sda_out,
    output logic                    sda_oe,
    output logic [8*DATA_BYTES-1:0] wr_data,
    output logic                    wr_valid,
    output logic                    busy
);

    localparam int WORD_W     = 8 * DATA_BYTES;
    localparam int BYTE_CNT_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(DATA_BYTES - 1);

    i2c_state_t            state;
    logic [2:0]            bit_cnt;
    logic [BYTE_CNT_W-1:0] byte_cnt;
    logic [6:0]            shift;
    logic [7:0]            shift_next;
    logic [WORD_W-1:0]     rd_shift;
    logic [WORD_W-1:0]     staging;
    logic                  matched;
    logic                  rw;
    logic                  ack_phase;
    logic                  scl_rise;
    logic                  scl_fall;
    logic                  bus_cond;

    i2c_bus_edges edges (
        .clk      (clk),
        .reset    (reset),
        .scl      (scl),
        .sda      (sda_in),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .bus_cond (bus_cond)
    );

    assign shift_next = {shift, sda_in};

    // ack_phase splits each ACK slot into "drive on first fall, release on second fall"
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= 3'd0;
            byte_cnt  <= '0;
            shift     <= '0;
            rd_shift  <= '0;
            staging   <= '0;
            matched   <= 1'b0;
            rw        <= 1'b0;
            ack_phase <= 1'b0;
            sda_out   <= 1'b1;
            sda_oe    <= 1'b0;
            wr_data   <= '0;
            wr_valid  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            wr_valid <= 1'b0;
            if (bus_cond) begin
                if (state == ST_IDLE) begin
                    state    <= ST_ADDR;
                    bit_cnt  <= 3'd7;
                    byte_cnt <= '0;
                    busy     <= 1'b1;
                end else begin
                    state   <= ST_IDLE;
                    sda_oe  <= 1'b0;
                    sda_out <= 1'b1;
                    busy    <= 1'b0;
                end
            end else begin
                case (state)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift <= shift_next[6:0];
                            if (bit_cnt == 3'd0) begin
                                state     <= ST_ADDR_ACK;
                                matched   <= (shift_next[7 -: ADDR_WIDTH] == own_addr);
                                rw        <= sda_in;
                                ack_phase <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt - 3'd1;
                            end
                        end
                    end

                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!ack_phase) begin
                                if (matched) begin
                                    sda_oe    <= 1'b1;
                                    sda_out   <= ACK;
                                    ack_phase <= 1'b1;
                                    if (rw) rd_shift <= rd_data;
                                end else begin
                                    state <= ST_WAIT_STOP;
                                end
                            end else begin
                                bit_cnt  <= 3'd7;
                                byte_cnt <= '0;
                                if (rw) begin
                                    state    <= ST_RD_BYTE;
                                    sda_oe   <= 1'b1;
                                    sda_out  <= rd_shift[WORD_W-1];
                                    rd_shift <= {rd_shift[WORD_W-2:0], 1'b0};
                                end else begin
                                    state   <= ST_WR_BYTE;
                                    sda_oe  <= 1'b0;
                                    sda_out <= 1'b1;
                                end
                            end
                        end
                    end

                    // Bytes land little-endian in staging; wr_data only moves on completion
                    ST_WR_BYTE: begin
                        if (scl_rise) begin
                            shift <= shift_next[6:0];
                            if (bit_cnt == 3'd0) begin
                                for (int k = 0; k < DATA_BYTES; k++) begin
                                    if (byte_cnt == BYTE_CNT_W'(k)) staging[8*k +: 8] <= shift_next;
                                end
                                state     <= ST_WR_ACK;
                                ack_phase <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt - 3'd1;
                            end
                        end
                    end

                    ST_WR_ACK: begin
                        if (scl_fall) begin
                            if (!ack_phase) begin
                                sda_oe    <= 1'b1;
                                sda_out   <= ACK;
                                ack_phase <= 1'b1;
                                if (byte_cnt == LAST_BYTE) begin
                                    wr_valid <= 1'b1;
                                    wr_data  <= staging;
                                end
                            end else begin
                                sda_oe  <= 1'b0;
                                sda_out <= 1'b1;
                                if (byte_cnt == LAST_BYTE) begin
                                    state <= ST_WAIT_STOP;
                                end else begin
                                    state    <= ST_WR_BYTE;
                                    byte_cnt <= byte_cnt + 1'b1;
                                    bit_cnt  <= 3'd7;
                                end
                            end
                        end
                    end

                    ST_RD_BYTE: begin
                        if (scl_fall) begin
                            if (bit_cnt == 3'd0) begin
                                state     <= ST_RD_ACK;
                                sda_oe    <= 1'b0;
                                sda_out   <= 1'b1;
                                ack_phase <= 1'b0;
                            end else begin
                                bit_cnt  <= bit_cnt - 3'd1;
                                sda_out  <= rd_shift[WORD_W-1];
                                rd_shift <= {rd_shift[WORD_W-2:0], 1'b0};
                            end
                        end
                    end

                    // After the host ACKs, the next byte's MSB goes out on the following fall
                    ST_RD_ACK: begin
                        if (!ack_phase && scl_rise) begin
                            if (sda_in == ACK && byte_cnt != LAST_BYTE) begin
                                ack_phase <= 1'b1;
                                byte_cnt  <= byte_cnt + 1'b1;
                            end else begin
                                state <= ST_WAIT_STOP;
                            end
                        end else if (ack_phase && scl_fall) begin
                            state    <= ST_RD_BYTE;
                            bit_cnt  <= 3'd7;
                            sda_oe   <= 1'b1;
                            sda_out  <= rd_shift[WORD_W-1];
                            rd_shift <= {rd_shift[WORD_W-2:0], 1'b0};
                        end
                    end

                    ST_IDLE, ST_WAIT_STOP: begin
                    end

                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_receptor.sv
// Bench for i2c_receptor: a bit-level host model drives scl/sda, write words are
// scoreboarded against the wr_valid monitor, read words checked on the bus.
module tb_i2c_receptor;
    import i2c_pkg::*;

    localparam int DATA_BYTES = 2;
    localparam int HALF       = 4;

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic        scl      = 1'b1;
    logic        sda_in   = 1'b0;
    logic [6:0]  own_addr = 7'h2A;
    logic [15:0] rd_data  = 16'h0000;
    logic        sda_out;
    logic        sda_oe;
    logic [15:0] wr_data;
    logic        wr_valid;
    logic        busy;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_q[$];
    logic [15:0] model_wr_data = 16'h0000;
    logic [15:0] mon_exp;
    logic        prev_valid = 1'b0;
    int          oe_cycles  = 0;

    logic [6:0]  r_addr;
    logic        r_rw;
    int          r_nb;

    always #5 clk = ~clk;

    i2c_receptor #(.ADDR_WIDTH(7), .DATA_BYTES(DATA_BYTES)) dut (
        .clk      (clk),
        .reset    (reset),
        .scl      (scl),
        .sda_in   (sda_in),
        .own_addr (own_addr),
        .rd_data  (rd_data),
        .sda_out  (sda_out),
        .sda_oe   (sda_oe),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .busy     (busy)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    // Monitor: pops the expected write word whenever the DUT reports one
    always @(negedge clk) begin
        if (!reset) begin
            prev_valid = 1'b0;
        end else begin
            if (sda_oe) oe_cycles++;
            else checkOutput("release_level", sda_out, 1);
            if (wr_valid) begin
                checkOutput("wr_valid_one_clk", prev_valid, 0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_wr_valid: got pulse with wr_data=%h, want none", wr_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    checkOutput("wr_data", wr_data, mon_exp);
                end
            end
            prev_valid = wr_valid;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic bus_line();
        return sda_oe ? sda_out : 1'b1;
    endfunction

    task automatic send_bit(input logic b);
        sda_in = b;
        tick(HALF);
        scl = 1'b1;
        tick(HALF);
        scl = 1'b0;
        tick(HALF);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic recv_bit(output logic b);
        sda_in = 1'b1;
        tick(HALF);
        scl = 1'b1;
        tick(HALF);
        b = bus_line();
        scl = 1'b0;
        tick(HALF);
    endtask

    task automatic gen_ack(input logic a);
        sda_in = a;
        tick(HALF);
        scl = 1'b1;
        tick(HALF);
        checkOutput("oe_in_host_ack", sda_oe, 0);
        scl = 1'b0;
        tick(HALF);
    endtask

    task automatic gen_start();
        sda_in = 1'b0;
        tick(HALF);
        sda_in = 1'b1;
        tick(HALF);
        scl = 1'b0;
        tick(HALF);
    endtask

    task automatic gen_stop();
        scl = 1'b0;
        sda_in = 1'b0;
        tick(HALF);
        scl = 1'b1;
        tick(HALF);
        sda_in = 1'b1;
        tick(HALF);
    endtask

    // One host transaction; nbytes < DATA_BYTES on a write means STOP early
    task automatic applyStimulus(input logic [6:0] addr, input logic rw, input logic [15:0] word, input int nbytes);
        logic       a;
        logic [7:0] rx;
        logic [15:0] got;
        bit         match;
        int         oe_start;
        match    = (addr == own_addr);
        oe_start = oe_cycles;
        rx       = 8'h00;
        got      = 16'h0000;
        gen_start();
        checkOutput("busy_after_start", busy, 1);
        send_byte({addr, rw});
        recv_bit(a);
        checkOutput("addr_ack", a, match ? ACK : NACK);
        if (match && !rw) begin
            for (int k = 0; k < nbytes; k++) begin
                if (k == DATA_BYTES - 1) exp_q.push_back(word);
                send_byte(word[8*k +: 8]);
                recv_bit(a);
                checkOutput("data_ack", a, ACK);
            end
            if (nbytes == DATA_BYTES) model_wr_data = word;
        end else if (match && rw) begin
            for (int k = 0; k < DATA_BYTES; k++) begin
                for (int i = 0; i < 8; i++) begin
                    recv_bit(a);
                    rx = {rx[6:0], a};
                end
                checkOutput("rd_byte", rx, rd_data[8*(DATA_BYTES-1-k) +: 8]);
                got = {got[7:0], rx};
                gen_ack((k == DATA_BYTES - 1) ? NACK : ACK);
            end
            checkOutput("rd_word", got, rd_data);
        end else begin
            checkOutput("no_drive_unmatched", oe_cycles - oe_start, 0);
        end
        gen_stop();
        tick(2);
        checkOutput("busy_after_stop", busy, 0);
        checkOutput("wr_data_held", wr_data, model_wr_data);
    endtask

    task automatic reset_mid_read();
        logic a;
        rd_data = 16'hC3A5;
        gen_start();
        send_byte({own_addr, 1'b1});
        recv_bit(a);
        checkOutput("rst_addr_ack", a, ACK);
        for (int i = 0; i < 3; i++) recv_bit(a);
        checkOutput("rst_driving_before", sda_oe, 1);
        checkOutput("rst_bit_before", sda_out, 0);
        #2 reset = 1'b0;
        #1;
        checkOutput("rst_sda_oe", sda_oe, 0);
        checkOutput("rst_sda_out", sda_out, 1);
        scl    = 1'b1;
        sda_in = 1'b0;
        tick(3);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_wr_data", wr_data, 0);
        model_wr_data = 16'h0000;
        reset = 1'b1;
        tick(3);
    endtask

    initial begin
        reset  = 1'b0;
        scl    = 1'b1;
        sda_in = 1'b0;
        tick(3);
        checkOutput("reset_sda_oe", sda_oe, 0);
        checkOutput("reset_sda_out", sda_out, 1);
        checkOutput("reset_wr_data", wr_data, 0);
        checkOutput("reset_wr_valid", wr_valid, 0);
        checkOutput("reset_busy", busy, 0);
        reset = 1'b1;
        tick(3);

        $display("[TB] directed transactions");
        applyStimulus(7'h2A, 1'b0, 16'h00EF, 1);
        applyStimulus(7'h2A, 1'b0, 16'hBEEF, 2);
        rd_data = 16'h1234;
        applyStimulus(7'h2A, 1'b1, 16'h0000, 0);
        applyStimulus(7'h2B, 1'b0, 16'h5555, 2);
        applyStimulus(7'h2B, 1'b1, 16'h0000, 0);
        reset_mid_read();
        applyStimulus(7'h2A, 1'b0, 16'hA55A, 2);
        applyStimulus(7'h2A, 1'b0, 16'h0001, 2);
        applyStimulus(7'h2A, 1'b0, 16'hFFFF, 2);

        $display("[TB] random transactions");
        for (int t = 0; t < 20; t++) begin
            r_addr  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h2A;
            r_rw    = 1'($urandom);
            r_nb    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 1)) : DATA_BYTES;
            rd_data = 16'($urandom);
            applyStimulus(r_addr, r_rw, 16'($urandom), r_nb);
        end

        tick(4);
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        checkOutput("final_wr_data", wr_data, model_wr_data);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_receptor.md
Name: i2c_receptor

Overview:
- I2C target (receiver) stage that sits directly downstream of the team's I2C transaction generator.
- Consumes the generator's scl and sda_out, and drives the generator's sda_in with ACKs and read data.
- Decodes one 7-bit address plus R/W byte, then either captures a DATA_BYTES-byte write or returns a DATA_BYTES-byte read word.
- Runs on the same clk as the generator; scl and sda are same-domain, so no synchronizers are needed.

Parameters:
ADDR_WIDTH, 7, target address width
DATA_BYTES, 2, bytes per transaction (byte counter width = clog2(DATA_BYTES))

Ports:
clk  input  1  system clock, shared with generator
reset  input  1  asynchronous, active-low
scl  input  1  bus clock from generator, idles high
sda_in  input  1  generator sda_out
own_addr  input  ADDR_WIDTH  this target's address, static during a transaction
rd_data  input  8*DATA_BYTES  word returned on read; sampled at address ACK
sda_out  output  1  to generator sda_in; 1 whenever sda_oe=0 (pull-up model)
sda_oe  output  1  1 while receptor drives the bus
wr_data  output  8*DATA_BYTES  last completed write word
wr_valid  output  1  one-clk pulse when wr_data updates
busy  output  1  high from START until return to IDLE

Behaviour:
- Reset values (async, reset=0): state=IDLE, sda_oe=0, sda_out=1, wr_data=0, wr_valid=0, busy=0, all counters 0, scl_q=1, sda_q=0.
- Edge detect: scl_q and sda_q registered each clk.
  - scl_rise = scl & ~scl_q
  - scl_fall = ~scl & scl_q
  - bus_cond = scl & scl_q & sda_in & ~sda_q (SDA rising while SCL high)
- Bus conditions:
  - bus_cond in IDLE = START: go to ADDR, bit_cnt=7, busy=1.
  - bus_cond in any other state = STOP/abort: go to IDLE next clk, sda_oe=0, no wr_valid.
- Sampling and driving:
  - Data bits are sampled on the clk where scl_rise is seen, MSB first.
  - sda_out/sda_oe change only on the clk after scl_fall, so they are stable before the generator samples on the next SCL rise.
- States:
  - ADDR: shift 8 bits on scl_rise. On the 8th bit, go to ADDR_ACK; the match flag is set when shift[7:1]==own_addr.
  - ADDR_ACK:
    - On the next scl_fall, if matched: sda_oe=1, sda_out=0. On the R/W=1 path, latch rd_data into the read shift register.
    - If not matched: sda_oe stays 0, the bus reads 1 (NACK), go to WAIT_STOP.
    - On the following scl_fall, release the bus and go to WR_BYTE (R/W=0) or RD_BYTE (R/W=1). For RD_BYTE, drive the first data bit in the same cycle.
  - WR_BYTE:
    - Shift 8 bits.
    - Byte k (k=0 first) lands in wr_data[8k+7:8k]: first byte to [7:0], second to [15:8].
    - After the 8th bit, go to WR_ACK.
  - WR_ACK: drive ACK (sda_oe=1, sda_out=0) for one SCL period, with the same fall-to-fall timing as ADDR_ACK.
    - If byte_cnt==DATA_BYTES-1: pulse wr_valid for exactly 1 clk when the ACK is asserted, then go to WAIT_STOP.
    - Otherwise: byte_cnt+1, return to WR_BYTE.
  - RD_BYTE:
    - Drive 8 bits from rd_data, MSB first. Byte order is rd_data[15:8] first, then rd_data[7:0].
    - Each bit changes on the clk after scl_fall.
    - After the 8th bit, release the bus (sda_oe=0) and go to RD_ACK.
  - RD_ACK: sample the generator's ACK on scl_rise.
    - ACK=0 and more bytes remain: go to RD_BYTE.
    - Last byte or NACK=1: go to WAIT_STOP.
  - WAIT_STOP: bus released; wait for bus_cond, then go to IDLE.
- wr_data holds its value until the next completed write. A partial (aborted) write never modifies wr_data; shift into a staging register and copy on completion.
- Simultaneous scl_rise and bus_cond cannot occur, since bus_cond requires scl_q=1. bus_cond takes priority over all data handling.
- Reset mid-transfer: immediate release (sda_oe=0, sda_out=1); the next transaction requires a fresh START.

Decomposition:
- Shared package i2c_pkg:
  - State encoding constants, shared with the generator's state list style.
  - ACK=0 / NACK=1 constants.
  - Default DATA_BYTES.
- One natural sub-module: i2c_bus_edges (scl/sda registers plus scl_rise, scl_fall, bus_cond outputs). It is reusable by the generator bench monitor.

Test Plan:
- own_addr=7'h2A, generator writes wr_data=16'hBEEF to 7'h2A -> ACK on the address and both bytes; wr_data=16'hBEEF; wr_valid high exactly 1 clk; busy falls after STOP.
- own_addr=7'h2A, rd_data=16'h1234, generator reads 7'h2A -> bus bits 0x12 then 0x34, MSB first; sda_oe=0 during the generator's ACK slots; generator rd_data word = 16'h1234.
- Generator addresses 7'h2B -> sda_oe never asserts; generator sees NACK and issues STOP; wr_valid stays 0; receptor returns to IDLE.
- STOP (SDA rise with SCL high) after first write byte 8'hEF -> return to IDLE; wr_data keeps its prior value (16'h0000 after reset); no wr_valid.
- reset asserted mid-RD_BYTE bit 3 -> sda_oe=0 and sda_out=1 in the same cycle; after release, a write of 16'hA55A completes correctly.
- Back-to-back writes 16'h0001 then 16'hFFFF -> two wr_valid pulses; wr_data ends at 16'hFFFF.
